ps2_host_tx: RTL and testbench

PS2_HOST_TX -- requirements
Module: ps2_host_tx

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_line_sync.sv | 21 ++
 rtl/ps2_host_tx.sv | 134 +++++++++++++
 tb/tb_ps2_host_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: PS/2 state encoding, parity helper and timing defaults shared by host tx/rx
package ps2_pkg;

    localparam int INHIBIT_DEFAULT = 6000;
    localparam int TIMEOUT_DEFAULT = 1000000;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        DATA,
        PARITY,
        STOP,
        ACK,
        WAIT_IDLE
    } ps2_state_t;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// ps2_line_sync: 2-flop synchronizer for a PS/2 line with falling-edge detect
module ps2_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic line_sync,
    output logic fall
);

    logic [2:0] sr;

    // two metastability flops plus one history flop; lines idle high
    always_ff @(posedge clk) begin
        if (rst) sr <= '1;
        else     sr <= {sr[1:0], line_in};
    end

    assign line_sync = sr[1];
    assign fall      = sr[2] & ~sr[1];

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: host-to-device PS/2 command byte transmitter with ack check and timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = INHIBIT_DEFAULT,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_ready,
    output logic       done,
    output logic       err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    ps2_state_t  state, state_n;
    logic [IW-1:0] icnt;
    logic [TW-1:0] tcnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        par;
    logic        ack;
    logic        clk_s, clk_fe;
    logic [1:0]  dsync;
    logic        data_s;
    logic        in_frame;
    logic        timeout;

    ps2_line_sync u_clk_sync (
        .clk       (clk),
        .rst       (rst),
        .line_in   (ps2_clk_in),
        .line_sync (clk_s),
        .fall      (clk_fe)
    );

    // data line only needs resynchronizing; it is sampled on clock edges
    always_ff @(posedge clk) begin
        if (rst) dsync <= '1;
        else     dsync <= {dsync[0], ps2_data_in};
    end

    assign data_s   = dsync[1];
    assign in_frame = state inside {START, DATA, PARITY, STOP};
    assign timeout  = in_frame && (tcnt == TW'(TIMEOUT_CYCLES));

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // next state and line/handshake outputs; a timeout overrides everything
    always_comb begin
        state_n     = state;
        tx_ready    = 1'b0;
        ps2_clk_oe  = 1'b0;
        ps2_data_oe = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                tx_ready = 1'b1;
                if (tx_valid) state_n = INHIBIT;
            end
            INHIBIT: begin
                ps2_clk_oe  = 1'b1;
                ps2_data_oe = (icnt == IW'(INHIBIT_CYCLES - 1));
                if (ps2_data_oe) state_n = START;
            end
            START: begin
                ps2_data_oe = 1'b1;
                if (clk_fe) state_n = DATA;
            end
            DATA: begin
                ps2_data_oe = ~shreg[idx];
                if (clk_fe && idx == 3'd7) state_n = PARITY;
            end
            PARITY: begin
                ps2_data_oe = ~par;
                if (clk_fe) state_n = STOP;
            end
            STOP: begin
                if (clk_fe) state_n = WAIT_IDLE;
            end
            WAIT_IDLE: begin
                if (clk_s && data_s) begin
                    done    = ack;
                    err     = ~ack;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            ps2_clk_oe  = 1'b0;
            ps2_data_oe = 1'b0;
            done        = 1'b0;
            err         = 1'b1;
            state_n     = IDLE;
        end
    end

    // counters, byte latch, bit index and ack capture
    always_ff @(posedge clk) begin
        if (rst) begin
            icnt  <= '0;
            tcnt  <= '0;
            idx   <= '0;
            shreg <= '0;
            par   <= 1'b0;
            ack   <= 1'b0;
        end else begin
            icnt <= (state == INHIBIT) ? icnt + 1'b1 : '0;
            tcnt <= in_frame ? tcnt + 1'b1 : '0;
            if (state == IDLE && tx_valid) begin
                shreg <= tx_data;
                par   <= odd_parity(tx_data);
                idx   <= '0;
            end
            if (state == DATA && clk_fe) idx <= idx + 1'b1;
            if (state == STOP && clk_fe) ack <= ~data_s;
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized PS/2 device model checking ps2_host_tx frames, ack/nack, timeout and reset
module tb_ps2_host_tx;

    localparam int INH = 6000;
    localparam int TO  = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tx_valid = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_ready, done, err;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       ps2_clk_in, ps2_data_in;
    logic       dev_clk = 1'b0;
    logic       dev_data = 1'b0;

    int checks = 0;
    int failures = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int inh_run = 0;
    int inh_data = 0;
    int last_inh = 0;
    int last_inh_data = 0;

    // open-drain wired-AND of host and device pull-downs
    assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk);
    assign ps2_data_in = ~(ps2_data_oe | dev_data);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .done        (done),
        .err         (err),
        .ps2_clk_in  (ps2_clk_in),
        .ps2_data_in (ps2_data_in),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // pulse counting and inhibit-length measurement
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (err) err_cnt++;
        if (done && err) check("done_err_excl", 32'(done & err), 0);
        if (ps2_clk_oe) begin
            inh_run++;
            if (ps2_data_oe) inh_data++;
        end else if (inh_run != 0) begin
            last_inh      = inh_run;
            last_inh_data = inh_data;
            inh_run       = 0;
            inh_data      = 0;
        end
    end

    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("send_ready", 32'(tx_ready), 1);
        tx_valid = 1'b1;
        tx_data  = b;
        @(negedge clk);
        tx_valid = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    // device side: wait for the host request, then clock nrise bits reading on rising edges
    task automatic device(input bit do_ack, input int half, input int nrise,
                          output logic [9:0] bits, output bit ok);
        int t = 0;
        ok   = 1'b1;
        bits = '0;
        while (!ps2_clk_oe && t < 20000) begin
            @(negedge clk);
            t++;
        end
        while (ps2_clk_oe && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20000) begin
            ok = 1'b0;
            return;
        end
        repeat (half) @(negedge clk);
        for (int k = 1; k <= nrise; k++) begin
            dev_clk = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk = 1'b0;
            if (k <= 10) bits[k-1] = ps2_data_in;
            if (k == 10 && do_ack) begin
                repeat (half / 2) @(negedge clk);
                dev_data = 1'b1;
                repeat (half - half / 2) @(negedge clk);
            end else begin
                repeat (half) @(negedge clk);
            end
            if (k == 11) dev_data = 1'b0;
        end
    endtask

    task automatic run_frame(input logic [7:0] b, input bit do_ack, input int half);
        logic [9:0] bits;
        bit ok;
        int d0, e0, t;
        d0 = done_cnt;
        e0 = err_cnt;
        send(b);
        device(do_ack, half, 11, bits, ok);
        check("dev_request", 32'(ok), 1);
        check("data_bits", 32'(bits[7:0]), 32'(b));
        check("parity_bit", 32'(bits[8]), ($countones(b) % 2 == 0) ? 1 : 0);
        check("stop_bit", 32'(bits[9]), 1);
        t = 0;
        while (done_cnt == d0 && err_cnt == e0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        repeat (5) @(negedge clk);
        check("done_count", done_cnt, d0 + (do_ack ? 1 : 0));
        check("err_count", err_cnt, e0 + (do_ack ? 0 : 1));
        check("inhibit_len", last_inh, INH);
        check("inhibit_data_cycles", last_inh_data, 1);
        check("idle_after", {ps2_clk_oe, ps2_data_oe, tx_ready}, 3'b001);
    endtask

    initial begin
        logic [9:0] bits;
        bit ok;
        int d0, e0, t, n;

        repeat (4) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("rst_pulses", {done, err}, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // device clock activity while idle must be ignored
        for (int i = 0; i < 4; i++) begin
            dev_clk = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk = 1'b0;
            repeat (20) @(negedge clk);
        end
        check("idle_edges_ready", 32'(tx_ready), 1);
        check("idle_edges_pulses", done_cnt + err_cnt, 0);

        run_frame(8'hED, 1'b1, 20);
        run_frame(8'hF4, 1'b1, 20);
        run_frame(8'hA5, 1'b0, 18);

        // device never clocks: timeout
        e0 = err_cnt;
        d0 = done_cnt;
        send(8'hF0);
        t = 0;
        while (!ps2_clk_oe && t < 20000) begin
            @(negedge clk);
            t++;
        end
        while (ps2_clk_oe && t < 20000) begin
            @(negedge clk);
            t++;
        end
        n = 0;
        while (!err && n < TO + 100) begin
            @(negedge clk);
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        @(negedge clk);
        check("timeout_idle", 32'(tx_ready), 1);
        check("timeout_err_count", err_cnt, e0 + 1);
        check("timeout_done_count", done_cnt, d0);

        // reset mid-frame after bit 3 of 0xAA
        send(8'hAA);
        device(1'b1, 20, 4, bits, ok);
        check("abort_request", 32'(ok), 1);
        check("abort_bits", 32'(bits[3:0]), 32'h0A);
        d0 = done_cnt;
        e0 = err_cnt;
        rst = 1'b1;
        @(negedge clk);
        check("abort_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        check("abort_ready", 32'(tx_ready), 1);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        run_frame(8'h55, 1'b1, 20);

        // stray requests during a frame must not disturb it
        fork
            run_frame(8'hED, 1'b1, 20);
            begin
                repeat (3000) @(negedge clk);
                tx_data  = 8'h12;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                repeat (3200) @(negedge clk);
                tx_data  = 8'h12;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
            end
        join
        repeat (100) @(negedge clk);
        check("no_stray_frame", {ps2_clk_oe, tx_ready}, 2'b01);

        for (int i = 0; i < 3; i++)
            run_frame(8'($urandom), 1'($urandom_range(0, 1)), int'($urandom_range(12, 30)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
